branch_cmp_pipe: RTL and testbench
==================================

// Module: branch_cmp_pipe
// PURPOSE
//  Parametrised, pipelined branch-condition unit for the decode/EX branch path.
//  - Evaluates one of ten compare conditions on operands a/b: signed, unsigned, or against zero.
//  - Result passes through STAGES elastic register slots with valid/ready handshake and flush.
//  - Supersedes the purely combinational compare flags.
//  - Also counts illegal condition codes for debug.
// PARAMETERS
//  WIDTH   32  operand width in bits (>=2)
//  STAGES  1   register slots between input and output (1..3); latency in cycles
//  CNT_W   8   width of saturating illegal-condition counter
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/cond presented
//  in_ready   out  1      unit accepts this cycle (in_valid & in_ready = accept)
//  a          in   WIDTH  operand rs
//  b          in   WIDTH  operand rt (ignored by *Z conditions)
//  cond       in   4      condition code, see BEHAVIOUR
//  flush      in   1      kill all in-flight entries (branch resolved/exception)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result (out_valid & out_ready = retire)
//  taken      out  1      condition true
//  illegal    out  1      cond of the presented result was undefined (taken forced 0)
//  ill_cnt    out  CNT_W  saturating count of accepted illegal conds
// BEHAVIOUR
//  - Reset (async, any time): all slot valids=0, taken=0, illegal=0, ill_cnt=0; in_ready=1 once reset deasserts.
//  - Cond codes:
//      0 EQ a==b | 1 NE a!=b | 2 LEZ $signed(a)<=0 | 3 GTZ >0 | 4 LTZ <0 | 5 GEZ >=0
//      6 LT $signed(a)<$signed(b) | 7 GE | 8 LTU a<b | 9 GEU a>=b
//      10..15 illegal: taken=0, illegal=1.
//  - Comparison is combinational on input; result is captured into slot 0 on accept.
//    Only {taken, illegal} travel down the pipe, not the operands.
//  - Slot k advances when slot k+1 is empty or advancing; last slot advances on out_ready.
//  - in_ready = !flush & (!slot0_valid | slot0_advancing). No bubble required at full throughput.
//  - Latency: accept in cycle N -> out_valid in cycle N+STAGES (no back-pressure).
//  - Full: with out_ready=0, accepts exactly STAGES entries, then in_ready=0. Results are held stable while stalled.
//  - flush: all slot valids cleared at next edge.
//      - The entry presented during the flush cycle is NOT accepted (in_ready=0).
//      - out_valid may be 1 in the flush cycle; if out_ready=1 it retires normally that cycle.
//  - Simultaneous retire+accept when full: allowed, occupancy unchanged.
//  - ill_cnt increments on accept of an illegal cond (not at output).
//      - Saturates at 2^CNT_W-1 and never wraps.
//      - Not cleared by flush; cleared only by reset.
//  - Width rules: zero compares use WIDTH-bit signed 0; no operand extension inside the unit.
// STRUCTURE
//  - Package cmp_pkg: cond code localparams (CMP_EQ..CMP_GEU), CMP_COND_W=4, and the function cmp_eval(a,b,cond) -> {illegal,taken}.
//  - Sub-module cmp_slot: one elastic register slot holding {valid, taken, illegal}.
//      - Ports up_valid/up_ready/dn_valid/dn_ready, plus flush.
//      - Instantiated STAGES times in a generate loop.
//  - Top: eval logic, slot chain, ill_cnt counter.
// TESTING
//  1. All conds, WIDTH=32, STAGES=1.
//     a=0xFFFFFFFF, b=1: EQ0 NE1 LEZ1 GTZ0 LTZ1 GEZ0 LT1 GE0 LTU0 GEU1, each out_valid exactly 1 cycle after accept.
//  2. Boundaries, a=0: LEZ1 GTZ0 LTZ0 GEZ1.
//     a=0x80000000, b=0x7FFFFFFF: LT1 LTU0.
//  3. Back-pressure, STAGES=3, out_ready=0, in_valid=1 continuous:
//     3 accepts, then in_ready=0; release out_ready -> 3 results in order, then stream resumes one per cycle.
//  4. Flush with 2 entries in flight, STAGES=3: out_valid=0 the next cycle; the input held during flush is not accepted; a new entry gets out_valid 3 cycles after its accept.
//  5. Illegal cond=12: taken=0, illegal=1, ill_cnt 0->1.
//     With CNT_W=2: 5 illegal accepts -> ill_cnt=3 (saturated).
//  6. Assert reset mid-stream with 2 valid entries: out_valid=0 and ill_cnt=0 immediately (async), in_ready=1 after deassert.

Source files
------------

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pkg
//  Description : Branch-compare condition codes, result type and the
//                condition evaluation function shared by the branch
//                compare pipeline.
//  Contents    : CMP_COND_W, CMP_EQ..CMP_GEU, cmp_res_t, cmp_eval()
//  Revision    : 1.0  initial release
// ============================================================================
package cmp_pkg;

    localparam int CMP_COND_W = 4;

    localparam logic [CMP_COND_W-1:0] CMP_EQ  = 4'd0;
    localparam logic [CMP_COND_W-1:0] CMP_NE  = 4'd1;
    localparam logic [CMP_COND_W-1:0] CMP_LEZ = 4'd2;
    localparam logic [CMP_COND_W-1:0] CMP_GTZ = 4'd3;
    localparam logic [CMP_COND_W-1:0] CMP_LTZ = 4'd4;
    localparam logic [CMP_COND_W-1:0] CMP_GEZ = 4'd5;
    localparam logic [CMP_COND_W-1:0] CMP_LT  = 4'd6;
    localparam logic [CMP_COND_W-1:0] CMP_GE  = 4'd7;
    localparam logic [CMP_COND_W-1:0] CMP_LTU = 4'd8;
    localparam logic [CMP_COND_W-1:0] CMP_GEU = 4'd9;

    typedef struct packed {
        logic illegal;
        logic taken;
    } cmp_res_t;

    // Operand width is a parameter of the instantiating module, so the
    // width-dependent primitives (equality, signed/unsigned less-than, sign
    // and zero of a) are formed at the call site at full operand width and
    // this function only selects among them.
    function automatic cmp_res_t cmp_eval(
        input logic                  eq,
        input logic                  lt_s,
        input logic                  lt_u,
        input logic                  a_neg,
        input logic                  a_zero,
        input logic [CMP_COND_W-1:0] cond
    );
        cmp_res_t res;
        res.illegal = 1'b0;
        res.taken   = 1'b0;
        case (cond)
            CMP_EQ  : res.taken = eq;
            CMP_NE  : res.taken = !eq;
            CMP_LEZ : res.taken = a_neg | a_zero;
            CMP_GTZ : res.taken = !a_neg & !a_zero;
            CMP_LTZ : res.taken = a_neg;
            CMP_GEZ : res.taken = !a_neg;
            CMP_LT  : res.taken = lt_s;
            CMP_GE  : res.taken = !lt_s;
            CMP_LTU : res.taken = lt_u;
            CMP_GEU : res.taken = !lt_u;
            default : res.illegal = 1'b1;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_slot.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_slot
//  Description : One elastic register slot of the branch compare pipeline,
//                holding {valid, taken, illegal}.
//  Ports       : clk, reset (async, active-high), flush (clears valid)
//                up_valid/up_ready/up_taken/up_illegal   - upstream side
//                dn_valid/dn_ready/dn_taken/dn_illegal   - downstream side
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_slot (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic up_valid,
    output logic up_ready,
    input  logic up_taken,
    input  logic up_illegal,
    output logic dn_valid,
    input  logic dn_ready,
    output logic dn_taken,
    output logic dn_illegal
);

    logic r_valid;
    logic r_taken;
    logic r_illegal;

    // Accept when empty or when the held entry leaves this same cycle, so a
    // full pipeline streams without bubbles.
    assign up_ready   = !r_valid | dn_ready;
    assign dn_valid   = r_valid;
    assign dn_taken   = r_taken;
    assign dn_illegal = r_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (up_ready) begin
                r_valid <= up_valid;
            end
            // Payload only changes on a real load, so a stalled result
            // stays stable at the output.
            if (up_valid && up_ready && !flush) begin
                r_taken   <= up_taken;
                r_illegal <= up_illegal;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_cmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cmp_pipe
//  Description : Pipelined branch-condition unit. Evaluates one of ten
//                compare conditions on a/b, then carries {taken, illegal}
//                through STAGES elastic slots with valid/ready and flush.
//                Counts accepted illegal condition codes (saturating).
//  Ports       : clk, reset (async, active-high)
//                in_valid/in_ready, a, b, cond, flush      - request side
//                out_valid/out_ready, taken, illegal       - result side
//                ill_cnt                                   - debug counter
//  Revision    : 1.0  initial release
// ============================================================================
module branch_cmp_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [CMP_COND_W-1:0] cond,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  taken,
    output logic                  illegal,
    output logic [CNT_W-1:0]      ill_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic       w_eq;
    logic       w_lt_s;
    logic       w_lt_u;
    logic       w_a_neg;
    logic       w_a_zero;
    cmp_res_t   w_res;
    logic       w_in_valid;
    logic       w_accept;
    logic [CNT_W-1:0] r_ill_cnt;

    assign w_eq     = (a == b);
    assign w_lt_s   = ($signed(a) < $signed(b));
    assign w_lt_u   = (a < b);
    assign w_a_neg  = a[WIDTH-1];
    assign w_a_zero = (a == '0);
    assign w_res    = cmp_eval(w_eq, w_lt_s, w_lt_u, w_a_neg, w_a_zero, cond);

    // The request presented during a flush is dropped, never loaded.
    assign w_in_valid = in_valid & !flush;
    assign in_ready   = !flush & g_slot[0].w_up_ready;
    assign w_accept   = in_valid & in_ready;

    // Each slot keeps its own handshake nets; neighbours are linked by
    // name so the ready chain is a plain net-to-net path.
    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        logic w_up_valid;
        logic w_up_ready;
        logic w_up_taken;
        logic w_up_illegal;
        logic w_dn_valid;
        logic w_dn_ready;
        logic w_dn_taken;
        logic w_dn_illegal;

        if (k == 0) begin : g_head
            assign w_up_valid   = w_in_valid;
            assign w_up_taken   = w_res.taken;
            assign w_up_illegal = w_res.illegal;
        end else begin : g_link
            assign w_up_valid   = g_slot[k-1].w_dn_valid;
            assign w_up_taken   = g_slot[k-1].w_dn_taken;
            assign w_up_illegal = g_slot[k-1].w_dn_illegal;
        end

        if (k == STAGES - 1) begin : g_tail
            assign w_dn_ready = out_ready;
        end else begin : g_mid
            assign w_dn_ready = g_slot[k+1].w_up_ready;
        end

        cmp_slot u_slot (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .up_valid   (w_up_valid),
            .up_ready   (w_up_ready),
            .up_taken   (w_up_taken),
            .up_illegal (w_up_illegal),
            .dn_valid   (w_dn_valid),
            .dn_ready   (w_dn_ready),
            .dn_taken   (w_dn_taken),
            .dn_illegal (w_dn_illegal)
        );
    end

    assign out_valid = g_slot[STAGES-1].w_dn_valid;
    assign taken     = g_slot[STAGES-1].w_dn_taken;
    assign illegal   = g_slot[STAGES-1].w_dn_illegal;

    // Counted at accept time, so flushed illegal requests still count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ill_cnt <= '0;
        end else if (w_accept && w_res.illegal && (r_ill_cnt != c_CNT_MAX)) begin
            r_ill_cnt <= r_ill_cnt + CNT_W'(1);
        end
    end

    assign ill_cnt = r_ill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_cmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_cmp_pipe
//  Description : Self-checking bench for branch_cmp_pipe. One instance with
//                STAGES=1/CNT_W=8 runs a vector table plus random vectors at
//                full throughput; one with STAGES=3/CNT_W=2 runs directed
//                handshake sequences and a random run against a scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_cmp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // STAGES=1 instance
    logic        s1_in_valid, s1_in_ready, s1_flush, s1_out_valid, s1_out_ready;
    logic        s1_taken, s1_illegal;
    logic [31:0] s1_a, s1_b;
    logic [3:0]  s1_cond;
    logic [7:0]  s1_ill_cnt;

    // STAGES=3, CNT_W=2 instance
    logic        s3_in_valid, s3_in_ready, s3_flush, s3_out_valid, s3_out_ready;
    logic        s3_taken, s3_illegal;
    logic [31:0] s3_a, s3_b;
    logic [3:0]  s3_cond;
    logic [1:0]  s3_ill_cnt;

    branch_cmp_pipe #(.WIDTH(32), .STAGES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .a(s1_a), .b(s1_b), .cond(s1_cond), .flush(s1_flush),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .taken(s1_taken), .illegal(s1_illegal), .ill_cnt(s1_ill_cnt)
    );

    branch_cmp_pipe #(.WIDTH(32), .STAGES(3), .CNT_W(2)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(s3_in_valid), .in_ready(s3_in_ready),
        .a(s3_a), .b(s3_b), .cond(s3_cond), .flush(s3_flush),
        .out_valid(s3_out_valid), .out_ready(s3_out_ready),
        .taken(s3_taken), .illegal(s3_illegal), .ill_cnt(s3_ill_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference semantics straight from the condition table: {illegal, taken}
    function automatic logic [1:0] ref_eval(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic            t, il;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        t  = 1'b0;
        il = 1'b0;
        case (c)
            4'd0:    t = (ua == ub);
            4'd1:    t = (ua != ub);
            4'd2:    t = (sa <= 0);
            4'd3:    t = (sa > 0);
            4'd4:    t = (sa < 0);
            4'd5:    t = (sa >= 0);
            4'd6:    t = (sa < sb);
            4'd7:    t = (sa >= sb);
            4'd8:    t = (ua < ub);
            4'd9:    t = (ua >= ub);
            default: il = 1'b1;
        endcase
        return {il, t};
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  cond;
        logic        taken;
        logic        illegal;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                           input logic t, input logic il);
        vec_t v;
        v.a = a; v.b = b; v.cond = c; v.taken = t; v.illegal = il;
        tbl.push_back(v);
    endtask

    // Scoreboard for the STAGES=3 instance: {illegal, taken} in accept order
    logic [1:0] sb_q[$];
    int         exp_cnt3 = 0;
    logic       acc, ov;

    task automatic step3(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, input logic ordy, input logic fl,
                         output logic o_acc, output logic o_ov);
        logic [1:0] r;
        s3_in_valid  = iv;
        s3_a         = a;
        s3_b         = b;
        s3_cond      = c;
        s3_out_ready = ordy;
        s3_flush     = fl;
        #1;
        chk("s3_ill_cnt", s3_ill_cnt, exp_cnt3);
        // Ready whenever any slot is empty or the tail is leaving, unless flushing
        chk("s3_in_ready", s3_in_ready, !fl && (sb_q.size() < 3 || ordy));
        if (sb_q.size() == 0) chk("s3_out_valid_empty", s3_out_valid, 1'b0);
        if (sb_q.size() == 3) chk("s3_out_valid_full", s3_out_valid, 1'b1);
        if (s3_out_valid && sb_q.size() > 0) begin
            chk("s3_taken", s3_taken, sb_q[0][0]);
            chk("s3_illegal", s3_illegal, sb_q[0][1]);
            if (ordy) void'(sb_q.pop_front());
        end
        o_ov  = s3_out_valid;
        o_acc = iv && s3_in_ready;
        if (fl) sb_q.delete();
        if (o_acc) begin
            r = ref_eval(a, b, c);
            sb_q.push_back(r);
            if (r[1] && exp_cnt3 < 3) exp_cnt3++;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_cnt1;
        vec_t v;
        logic [1:0] r;

        reset = 1'b1;
        s1_in_valid = 0; s1_a = 0; s1_b = 0; s1_cond = 0; s1_flush = 0; s1_out_ready = 1;
        s3_in_valid = 0; s3_a = 0; s3_b = 0; s3_cond = 0; s3_flush = 0; s3_out_ready = 0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_s1_out_valid", s1_out_valid, 1'b0);
        chk("rst_s1_taken", s1_taken, 1'b0);
        chk("rst_s1_illegal", s1_illegal, 1'b0);
        chk("rst_s1_ill_cnt", s1_ill_cnt, 8'd0);
        chk("rst_s3_out_valid", s3_out_valid, 1'b0);
        chk("rst_s3_ill_cnt", s3_ill_cnt, 2'd0);
        reset = 1'b0;
        #1;
        chk("rst_s1_in_ready", s1_in_ready, 1'b1);
        chk("rst_s3_in_ready", s3_in_ready, 1'b1);

        // ---------------- vector table (STAGES=1) ----------------
        add_vec(32'hFFFF_FFFF, 32'd1, 4'd0, 1'b0, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'd1, 4'd1, 1'b1, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'd1, 4'd2, 1'b1, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'd1, 4'd3, 1'b0, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'd1, 4'd4, 1'b1, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'd1, 4'd5, 1'b0, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'd1, 4'd6, 1'b1, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'd1, 4'd7, 1'b0, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'd1, 4'd8, 1'b0, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'd1, 4'd9, 1'b1, 1'b0);
        add_vec(32'd0, 32'h1234_5678, 4'd2, 1'b1, 1'b0);
        add_vec(32'd0, 32'h1234_5678, 4'd3, 1'b0, 1'b0);
        add_vec(32'd0, 32'h1234_5678, 4'd4, 1'b0, 1'b0);
        add_vec(32'd0, 32'h1234_5678, 4'd5, 1'b1, 1'b0);
        add_vec(32'h8000_0000, 32'h7FFF_FFFF, 4'd6, 1'b1, 1'b0);
        add_vec(32'h8000_0000, 32'h7FFF_FFFF, 4'd8, 1'b0, 1'b0);
        add_vec(32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd0, 1'b1, 1'b0);
        add_vec(32'h7FFF_FFFF, 32'h8000_0000, 4'd9, 1'b0, 1'b0);
        add_vec(32'h0000_0005, 32'h0000_0003, 4'd12, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            v.a    = pick_op();
            v.b    = ($urandom_range(0, 3) == 0) ? v.a : pick_op();
            v.cond = 4'($urandom_range(0, 15));
            r      = ref_eval(v.a, v.b, v.cond);
            v.taken   = r[0];
            v.illegal = r[1];
            tbl.push_back(v);
        end

        // Continuous stream: each result must appear exactly one cycle later
        exp_cnt1 = 0;
        for (int i = 0; i <= tbl.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("s1_out_valid_idle", s1_out_valid, 1'b0);
            end else begin
                chk($sformatf("s1_out_valid[%0d]", i - 1), s1_out_valid, 1'b1);
                chk($sformatf("s1_taken[%0d]", i - 1), s1_taken, tbl[i-1].taken);
                chk($sformatf("s1_illegal[%0d]", i - 1), s1_illegal, tbl[i-1].illegal);
            end
            chk($sformatf("s1_ill_cnt[%0d]", i), s1_ill_cnt, exp_cnt1);
            if (i < tbl.size()) begin
                s1_in_valid = 1'b1;
                s1_a        = tbl[i].a;
                s1_b        = tbl[i].b;
                s1_cond     = tbl[i].cond;
                #1;
                chk($sformatf("s1_in_ready[%0d]", i), s1_in_ready, 1'b1);
                if (tbl[i].illegal && exp_cnt1 < 255) exp_cnt1++;
            end else begin
                s1_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("s1_out_valid_drained", s1_out_valid, 1'b0);
        chk("s1_ill_cnt_final", s1_ill_cnt, exp_cnt1);

        // ---------------- back-pressure (STAGES=3) ----------------
        for (int i = 0; i < 6; i++) begin
            step3(1'b1, pick_op(), pick_op(), 4'($urandom_range(0, 9)), 1'b0, 1'b0, acc, ov);
            chk($sformatf("bp_accept[%0d]", i), acc, (i < 3));
            chk($sformatf("bp_out_valid[%0d]", i), ov, (i >= 3));
        end
        for (int i = 0; i < 8; i++) begin
            step3(1'b1, pick_op(), pick_op(), 4'($urandom_range(0, 9)), 1'b1, 1'b0, acc, ov);
            chk($sformatf("stream_accept[%0d]", i), acc, 1'b1);
            chk($sformatf("stream_out_valid[%0d]", i), ov, 1'b1);
        end
        for (int i = 0; i < 4; i++) step3(1'b0, 0, 0, 0, 1'b1, 1'b0, acc, ov);
        chk("drain_empty", sb_q.size(), 0);

        // ---------------- flush with two in flight ----------------
        step3(1'b1, pick_op(), pick_op(), 4'd6, 1'b0, 1'b0, acc, ov);
        step3(1'b1, pick_op(), pick_op(), 4'd8, 1'b0, 1'b0, acc, ov);
        step3(1'b1, 32'd7, 32'd7, 4'd0, 1'b0, 1'b1, acc, ov);
        chk("flush_no_accept", acc, 1'b0);
        step3(1'b1, 32'd7, 32'd7, 4'd0, 1'b1, 1'b0, acc, ov);
        chk("flush_out_valid_next", ov, 1'b0);
        chk("flush_new_accept", acc, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step3(1'b0, 0, 0, 0, 1'b1, 1'b0, acc, ov);
            chk($sformatf("flush_latency[%0d]", i), ov, (i == 3));
        end
        step3(1'b0, 0, 0, 0, 1'b1, 1'b0, acc, ov);

        // ---------------- illegal counter, CNT_W=2 ----------------
        step3(1'b1, 32'd1, 32'd2, 4'd12, 1'b1, 1'b0, acc, ov);
        step3(1'b0, 0, 0, 0, 1'b1, 1'b0, acc, ov);
        chk("ill_cnt_one", s3_ill_cnt, 2'd1);
        for (int i = 0; i < 4; i++) step3(1'b1, pick_op(), pick_op(), 4'd12, 1'b1, 1'b0, acc, ov);
        for (int i = 0; i < 4; i++) step3(1'b0, 0, 0, 0, 1'b1, 1'b0, acc, ov);
        chk("ill_cnt_saturated", s3_ill_cnt, 2'd3);

        // ---------------- random traffic against scoreboard ----------------
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            ra = pick_op();
            step3(($urandom_range(0, 3) != 0), ra,
                  ($urandom_range(0, 3) == 0) ? ra : pick_op(),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), acc, ov);
        end
        for (int i = 0; i < 4; i++) step3(1'b0, 0, 0, 0, 1'b1, 1'b0, acc, ov);

        // ---------------- async reset mid-stream ----------------
        step3(1'b1, 32'd3, 32'd4, 4'd6, 1'b0, 1'b0, acc, ov);
        step3(1'b1, 32'd3, 32'd4, 4'd13, 1'b0, 1'b0, acc, ov);
        chk("pre_reset_in_flight", sb_q.size(), 2);
        s3_in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_s3_out_valid", s3_out_valid, 1'b0);
        chk("async_rst_s3_ill_cnt", s3_ill_cnt, 2'd0);
        chk("async_rst_s1_ill_cnt", s1_ill_cnt, 8'd0);
        sb_q.delete();
        exp_cnt3 = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_s3_in_ready", s3_in_ready, 1'b1);
        chk("post_rst_s1_in_ready", s1_in_ready, 1'b1);
        @(negedge clk);
        step3(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 4'd6, 1'b1, 1'b0, acc, ov);
        for (int i = 1; i <= 3; i++) begin
            step3(1'b0, 0, 0, 0, 1'b1, 1'b0, acc, ov);
            chk($sformatf("post_rst_latency[%0d]", i), ov, (i == 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
